// File: rtl/tpu_tile_sequencer.sv
// -----------------------------------------------------------------------------
// tpu_tile_sequencer
//
// Sequences one matrix tile job: pops a weight tile from the weight FIFO,
// strobes a weight reload into the systolic array, streams num_rows input
// rows out of the unified buffer, and writes the matching result rows into
// the result SRAM RESULT_LAT cycles after each read.
//
// Ports
//   clk, rstn            : clock, asynchronous active-low reset
//   start, abort         : launch a job (IDLE only) / cancel the current job
//   src_base, dst_base   : first unified-buffer / result-SRAM address
//   num_rows             : number of rows to stream (0 is an illegal job)
//   fifo_empty, fifo_re  : weight FIFO status / pop strobe
//   we_rl                : weight reload strobe to the systolic array
//   ub_re, ub_addr       : unified-buffer read valid / address
//   res_we, res_addr     : result-SRAM write enable / address
//   busy, done, err      : job in progress / completion pulse / illegal pulse
// -----------------------------------------------------------------------------
module tpu_tile_sequencer #(
    parameter int ADDRESSSIZE = 10,
    parameter int MATRIX_SIZE = 8,
    parameter int RESULT_LAT  = 3 * MATRIX_SIZE
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   abort,
    input  logic [ADDRESSSIZE-1:0] src_base,
    input  logic [ADDRESSSIZE-1:0] dst_base,
    input  logic [ADDRESSSIZE-1:0] num_rows,
    input  logic                   fifo_empty,
    output logic                   fifo_re,
    output logic                   we_rl,
    output logic                   ub_re,
    output logic [ADDRESSSIZE-1:0] ub_addr,
    output logic                   res_we,
    output logic [ADDRESSSIZE-1:0] res_addr,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    if (RESULT_LAT < 1 || RESULT_LAT > 64 || MATRIX_SIZE < 1) begin : g_bad_params
        $error("tpu_tile_sequencer: RESULT_LAT must be 1..64 and MATRIX_SIZE >= 1");
    end

    typedef enum logic [2:0] {IDLE, WLOAD, WRL, STREAM, DRAIN} state_t;

    state_t                 state;
    logic [ADDRESSSIZE-1:0] rows;      // captured num_rows
    logic [ADDRESSSIZE-1:0] row_cnt;   // rows issued so far in STREAM
    logic [ADDRESSSIZE-1:0] res_cnt;   // result writes seen so far
    logic [ADDRESSSIZE-1:0] ub_ptr;
    logic [ADDRESSSIZE-1:0] res_ptr;
    logic [RESULT_LAT-1:0]  pipe;      // ub_re delay line; MSB is res_we

    // All strobes decode directly from registered state so they carry no
    // extra cycle of latency; fifo_re must react to fifo_empty in the same
    // cycle so the pop and the WLOAD->WRL step coincide.
    assign fifo_re  = (state == WLOAD) && !fifo_empty;
    assign we_rl    = (state == WRL);
    assign ub_re    = (state == STREAM);
    assign busy     = (state != IDLE);
    assign res_we   = pipe[RESULT_LAT-1];
    assign ub_addr  = ub_ptr;
    assign res_addr = res_ptr;

    // NOTE: every register here uses <= so all updates see the pre-edge
    // values; later assignments in the block deliberately override earlier
    // defaults (e.g. a new job reloads res_ptr over the running increment).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            rows    <= '0;
            row_cnt <= '0;
            res_cnt <= '0;
            ub_ptr  <= '0;
            res_ptr <= '0;
            // NOTE: the delay line is plain flops, not a RAM, so it is reset
            // along with everything else; a stale bit would fire res_we.
            pipe    <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            pipe <= (pipe << 1) | RESULT_LAT'(ub_re);

            // Result writes can trail into DRAIN or, for short latencies,
            // overlap STREAM, so their bookkeeping runs in every state.
            if (res_we) begin
                res_ptr <= res_ptr + ADDRESSSIZE'(1);
                res_cnt <= res_cnt + ADDRESSSIZE'(1);
            end

            if (abort && state != IDLE) begin
                // Abort wins over start and flushes in-flight result writes.
                state <= IDLE;
                pipe  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (num_rows == '0) begin
                                done <= 1'b1;
                                err  <= 1'b1;
                            end else begin
                                rows    <= num_rows;
                                ub_ptr  <= src_base;
                                res_ptr <= dst_base;
                                row_cnt <= '0;
                                res_cnt <= '0;
                                state   <= WLOAD;
                            end
                        end
                    end
                    WLOAD: begin
                        if (!fifo_empty) state <= WRL;
                    end
                    WRL: begin
                        state <= STREAM;
                    end
                    STREAM: begin
                        ub_ptr  <= ub_ptr + ADDRESSSIZE'(1);
                        row_cnt <= row_cnt + ADDRESSSIZE'(1);
                        // Compare against rows-1 so a full 2^N-1 row job never
                        // needs the counter to exceed its width.
                        if (row_cnt == rows - ADDRESSSIZE'(1)) state <= DRAIN;
                    end
                    DRAIN: begin
                        if (res_we && res_cnt == rows - ADDRESSSIZE'(1)) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tpu_tile_sequencer
//
// Directed and randomized tile jobs. For each job the expected cycle of every
// strobe is derived arithmetically from the job parameters (pop cycle, reload
// cycle, read window, write window, done cycle), and every output is compared
// against that timeline on each falling edge.
// -----------------------------------------------------------------------------
module tb_tpu_tile_sequencer;

    localparam int AW  = 10;
    localparam int LAT = 24;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] src_base = '0;
    logic [AW-1:0] dst_base = '0;
    logic [AW-1:0] num_rows = '0;
    logic          fifo_empty = 1'b1;
    logic          fifo_re, we_rl, ub_re, res_we, busy, done, err;
    logic [AW-1:0] ub_addr, res_addr;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tpu_tile_sequencer #(
        .ADDRESSSIZE(AW),
        .MATRIX_SIZE(8)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .abort     (abort),
        .src_base  (src_base),
        .dst_base  (dst_base),
        .num_rows  (num_rows),
        .fifo_empty(fifo_empty),
        .fifo_re   (fifo_re),
        .we_rl     (we_rl),
        .ub_re     (ub_re),
        .ub_addr   (ub_addr),
        .res_we    (res_we),
        .res_addr  (res_addr),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic check(input string tag, input int cyc, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s c%0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fifo_re"}, 0, 32'(fifo_re), 0);
        check({tag, "_we_rl"}, 0, 32'(we_rl), 0);
        check({tag, "_ub_re"}, 0, 32'(ub_re), 0);
        check({tag, "_ub_addr"}, 0, 32'(ub_addr), 0);
        check({tag, "_res_we"}, 0, 32'(res_we), 0);
        check({tag, "_res_addr"}, 0, 32'(res_addr), 0);
        check({tag, "_busy"}, 0, 32'(busy), 0);
        check({tag, "_done"}, 0, 32'(done), 0);
        check({tag, "_err"}, 0, 32'(err), 0);
    endtask

    // Cycle 0 is the cycle in which start is high. wait_cyc is the number of
    // WLOAD cycles spent with an empty FIFO. abort_at/restart_at/rst_at < 0
    // disable those events.
    task automatic run_job(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                           input logic [AW-1:0] n, input int wait_cyc,
                           input int abort_at, input int restart_at, input int rst_at);
        int            tw, done_c;
        bit            alive;
        logic          e_fre, e_wrl, e_ure, e_rwe, e_busy, e_done, e_err;
        logic [AW-1:0] ea;
        tw     = 1 + wait_cyc;
        done_c = (n == 0) ? 1 : tw + 2 + LAT + int'(n);
        for (int c = 0; c <= done_c + 2; c++) begin
            @(posedge clk);
            #1;
            start = (c == 0) || (c == restart_at) || (c == abort_at);
            abort = (c == abort_at);
            if (c == 0) begin
                src_base = src;
                dst_base = dst;
                num_rows = n;
            end else begin
                src_base = AW'($urandom);
                dst_base = AW'($urandom);
                num_rows = AW'($urandom);
            end
            if (c == tw) fifo_empty = 1'b0;
            else if (c >= 1 && c < tw) fifo_empty = 1'b1;
            else fifo_empty = 1'($urandom_range(0, 1));

            @(negedge clk);
            alive = (abort_at < 0) || (c <= abort_at);
            if (n == 0) begin
                {e_fre, e_wrl, e_ure, e_rwe, e_busy} = '0;
                e_done = (c == 1);
                e_err  = (c == 1);
            end else begin
                e_fre  = alive && (c == tw);
                e_wrl  = alive && (c == tw + 1);
                e_ure  = alive && (c >= tw + 2) && (c < tw + 2 + int'(n));
                e_rwe  = alive && (c >= tw + 2 + LAT) && (c < done_c);
                e_busy = alive && (c >= 1) && (c < done_c);
                e_done = alive && (c == done_c);
                e_err  = 1'b0;
            end
            check("fifo_re", c, 32'(fifo_re), 32'(e_fre));
            check("we_rl", c, 32'(we_rl), 32'(e_wrl));
            check("ub_re", c, 32'(ub_re), 32'(e_ure));
            check("res_we", c, 32'(res_we), 32'(e_rwe));
            check("busy", c, 32'(busy), 32'(e_busy));
            check("done", c, 32'(done), 32'(e_done));
            check("err", c, 32'(err), 32'(e_err));
            if (e_ure) begin
                ea = src + AW'(c - tw - 2);
                check("ub_addr", c, 32'(ub_addr), 32'(ea));
            end
            if (e_rwe) begin
                ea = dst + AW'(c - tw - 2 - LAT);
                check("res_addr", c, 32'(res_addr), 32'(ea));
            end
            if (c == rst_at) begin
                start = 1'b0;
                abort = 1'b0;
                rstn  = 1'b0;
                #1;
                check_all_zero("mid_reset");
                return;
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        int n, w, ab, rs, dc;

        // Reset state.
        rstn = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rstn = 1'b1;

        // Reference job.
        run_job(10'h010, 10'h200, 10'd4, 0, -1, -1, -1);
        // Zero-row job is illegal.
        run_job(10'h055, 10'h155, 10'd0, 0, -1, -1, -1);
        // FIFO empty for the first cycles of WLOAD.
        run_job(10'h010, 10'h200, 10'd4, 5, -1, -1, -1);
        // Address wrap on both buses.
        run_job(10'h3FE, 10'h3FF, 10'd4, 0, -1, -1, -1);
        // Start while busy is ignored; abort (with start) cancels the job.
        run_job(10'h010, 10'h200, 10'd4, 0, 20, 4, -1);
        // Asynchronous reset mid-job, then a fresh reference job.
        run_job(10'h010, 10'h200, 10'd4, 0, -1, -1, 5);
        @(posedge clk);
        #2;
        check_all_zero("held_reset");
        @(negedge clk);
        rstn = 1'b1;
        run_job(10'h010, 10'h200, 10'd4, 0, -1, -1, -1);

        // Randomized jobs, some aborted part way through.
        for (int j = 0; j < 10; j++) begin
            n  = $urandom_range(1, 40);
            w  = $urandom_range(0, 4);
            dc = 1 + w + 2 + LAT + n;
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, dc - 1) : -1;
            rs = $urandom_range(1, w + 2);
            if (ab >= 0 && rs > ab) rs = -1;
            run_job(AW'($urandom), AW'($urandom), AW'(n), w, ab, rs, -1);
        end

        // Largest legal row count.
        run_job(AW'($urandom), AW'($urandom), 10'h3FF, 1, -1, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
